// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter / branch-resolution stage.
//   state_t    : run/halt state machine encoding (IDLE, RUN, DONE)
//   PC_W       : program-counter width (instruction memory depth 2^PC_W)
//   LUT_N      : number of branch-target table entries
//   BR_TARGETS : absolute branch targets, regenerated by the assembler
package cpu_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned LUT_N   = 16;
    localparam int unsigned LUT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Element 0 is listed first.
    localparam logic [PC_W-1:0] BR_TARGETS [LUT_N] = '{
        10'd0,   10'd5,   10'd12,  10'd40,
        10'd100, 10'd200, 10'd300, 10'd400,
        10'd500, 10'd600, 10'd700, 10'd800,
        10'd900, 10'd1000, 10'd1022, 10'd1023
    };

endpackage

// File: rtl/pc_ctrl_if.sv
// Harness/decoder/ALU <-> pc_ctrl signal bundle.
//   start, branch_en, notequal, lessthan, lut_idx, halt : toward pc_ctrl
//   prog_ctr, running, done                             : from pc_ctrl
// master: the driving side (decoder, ALU, harness); slave: pc_ctrl.
interface pc_ctrl_if;
    import cpu_pkg::*;

    logic             start;
    logic             branch_en;
    logic             notequal;
    logic             lessthan;
    logic [LUT_W-1:0] lut_idx;
    logic             halt;
    logic [PC_W-1:0]  prog_ctr;
    logic             running;
    logic             done;

    modport master (
        output start, branch_en, notequal, lessthan, lut_idx, halt,
        input  prog_ctr, running, done
    );

    modport slave (
        input  start, branch_en, notequal, lessthan, lut_idx, halt,
        output prog_ctr, running, done
    );

endinterface

// File: rtl/lut_branch.sv
// Combinational branch-target ROM.
//   lut_idx : table index (instruction immediate)
//   target  : absolute PC_W-bit branch target
module lut_branch
    import cpu_pkg::*;
(
    input  logic [LUT_W-1:0] lut_idx,
    output logic [PC_W-1:0]  target
);

    assign target = BR_TARGETS[lut_idx];

endmodule

// File: rtl/pc_ctrl.sv
// Program counter, branch resolution and run/halt state machine.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : pc_ctrl_if slave (start/branch/halt in; prog_ctr/running/done out)
module pc_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    pc_ctrl_if.slave    bus
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q;
    logic [PC_W-1:0] br_target;
    logic            br_taken;

    lut_branch u_lut (
        .lut_idx (bus.lut_idx),
        .target  (br_target)
    );

    // Flags are don't-care on non-branch ops, so branch_en gates them.
    assign br_taken = bus.branch_en & (bus.notequal | bus.lessthan);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    state_d = DONE;
                end else if (br_taken) begin
                    pc_d = br_target;
                end else if (pc_q == '1) begin
                    // Runaway guard: stop at the top of memory instead of wrapping.
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            default: begin
                pc_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = done_q;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and branch-resolution stage of the 8-bit core. Sits directly downstream of the ALU: it consumes the `notequal`/`lessthan` branch flags from the `bneq`/`blt` ops and produces the instruction-fetch address for the next cycle. It also owns the run/halt state machine behind the `start`/`done` handshake with the test harness. Branch targets are absolute and come from a small constant lookup table indexed by the instruction's 4-bit immediate.

## Interface
- `PC_W`, 10, program-counter width; instruction memory depth is 2^PC_W.
- `LUT_N`, 16, number of branch-target entries; index width is 4.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1  level request to begin or restart execution from address 0.
- `branch_en`  in  1  decoder marks the current instruction as `bneq` or `blt`.
- `notequal`  in  1  ALU flag; valid in the same cycle as `branch_en`.
- `lessthan`  in  1  ALU flag; valid in the same cycle as `branch_en`.
- `lut_idx`  in  4  branch-target table index (the instruction immediate).
- `halt`  in  1  decoder marks the current instruction as halt.
- `prog_ctr`  out  PC_W  registered fetch address.
- `running`  out  1  high while in RUN.
- `done`  out  1  registered; high while in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset leaves the block in IDLE with `prog_ctr` = 0, `done` = 0 and `running` = 0.
- **IDLE**
  - `prog_ctr` holds 0.
  - `start` = 1 moves to RUN. PC stays 0, so address 0 is the first instruction executed.
- **RUN**, evaluated every cycle in this priority order:
  1. `halt` = 1: go to DONE; PC holds.
  2. Branch taken (`branch_en` & (`notequal` | `lessthan`)): PC ← `lut[lut_idx]`.
  3. PC = 2^PC_W−1: go to DONE as a runaway guard; PC holds, no wrap.
  4. Otherwise: PC ← PC+1.
- `start` is ignored while in RUN.
- `branch_en` = 0 masks both flags, since the flags are don't-care for non-branch ops.
- **DONE**
  - `done` = 1 and PC holds.
  - `start` = 1: PC ← 0, go to RUN, and `done` falls on the same edge.
- A branch to its own address is legal and loops until reset.
- Reset mid-RUN or mid-DONE returns to IDLE, PC 0 and `done` 0 on that edge, regardless of the other inputs.
- If `reset` and `start` are asserted together, reset wins. RUN can be entered no earlier than the following cycle.
- LUT entries are unsigned PC_W-bit absolute addresses. There are no relative offsets and no sign extension.

## Timing
- `prog_ctr` changes only on clock edges; there are no combinational paths from the inputs to it.
- Branch decision latency is 1: the flags in cycle n select the PC presented in cycle n+1. There are no delay slots and no flush.
- `done` rises on the edge that samples `halt`, so it is visible in the next cycle. It stays high until `start` or `reset`.
- `running` is a decode of the state register and is glitch-free relative to `clk`.
- IDLE → RUN costs one cycle, and the fetch at address 0 occurs in the first RUN cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`);
  - `PC_W`;
  - the branch-target constant array `BR_TARGETS[16]`, which the assembler regenerates.
- Sub-module `lut_branch`: a combinational ROM mapping `lut_idx` to a PC_W-bit target, read from `cpu_pkg`.
- Top level: state register, PC register, next-PC mux.

## Test plan
- Reset, then `start` = 1 for 1 cycle, with no branches → `prog_ctr` reads 0, 1, 2, 3 on successive cycles and `running` = 1.
- In RUN at PC = 5, `branch_en` = 1, `notequal` = 1, `lut_idx` = 3 with `BR_TARGETS[3]` = 40 → PC = 40 next cycle. Repeat with `branch_en` = 0 → PC = 6.
- `halt` and a taken branch in the same cycle at PC = 12 → state DONE, PC stays 12, `done` = 1 next cycle.
- Run to PC = 1023 with no branch or halt → DONE, PC holds 1023 and does not wrap to 0.
- In DONE, assert `start` → PC = 0, `done` = 0, `running` = 1 next cycle. Assert `reset` at PC = 7 in RUN → PC = 0 and IDLE next cycle, even with `start` held high.
